vip_axi_ext_traffic_gen: RTL and testbench
==========================================

// Module: vip_axi_ext_traffic_gen
// PURPOSE
// Self-checking AXI4 master that drives one external virtual AXI slave port
// of the carfield SoC VIP, upstream of the serial-link AXI mux.
// Issues one INCR write burst with a deterministic pattern, reads the same
// range back and compares it. Reports completion and error status.
// One instance per external port; N instances exercise mux arbitration and ID remap.
// PARAMETERS
// AddrWidth  48        AXI address width
// DataWidth  64        AXI data width (power of two, >=32)
// IdWidth    2         AXI ID width (equals DutCfg.AxiMstIdWidth)
// UserWidth  1         AXI user width; aw/ar user driven '0
// TxnId      0         constant AXI ID on AW and AR
// MaxBeats   256       max burst length in beats
// axi_req_t  logic     AXI request struct (cheshire axi_mst_req_t)
// axi_rsp_t  logic     AXI response struct (cheshire axi_mst_rsp_t)
// PORTS
// clk_i        in   1                   system clock
// rst_ni       in   1                   async reset, active low
// start_i      in   1                   pulse; latches cfg when IDLE
// base_addr_i  in   AddrWidth           burst start address, DataWidth/8 aligned
// num_beats_i  in   $clog2(MaxBeats)+1  beats, 1..MaxBeats
// seed_i       in   32                  pattern seed
// busy_o       out  1                   high from accepted start to done
// done_o       out  1                   one-cycle pulse at end of test
// cfg_err_o    out  1                   config rejected; sticky until next start
// resp_err_o   out  1                   BRESP/RRESP != OKAY, or bad RID/RLAST
// mismatch_o   out  16                  read-data mismatch count, saturating
// axi_req_o    out  axi_req_t           master request
// axi_rsp_i    in   axi_rsp_t           master response
// BEHAVIOUR
// - Reset: all outputs 0; all AXI valids/readies 0; FSM in IDLE.
// - FSM: IDLE -> AW -> W -> B -> AR -> R -> DONE -> IDLE.
// - IDLE: start_i latches base/num/seed and clears status outputs.
//   If num_beats==0, num_beats>MaxBeats, or the burst crosses a 4 KiB boundary:
//   set cfg_err, pulse done next cycle, issue no AXI traffic.
//   start_i outside IDLE is ignored.
// - AW: len=num-1, size=log2(DataWidth/8), burst=INCR, id=TxnId, cache/prot/qos/
//   lock/region=0. Hold aw_valid and payload stable until aw_ready.
// - W: entered after the AW handshake; no W before AW.
//   Beat k: every 32-bit lane = seed+k (mod 2^32); strb all ones; last on k==num-1.
//   Hold w_valid until w_ready; k advances on handshake only.
// - B: b_ready=1. On handshake, bresp!=OKAY or bid!=TxnId sets resp_err and
//   skips to DONE (no read phase).
// - AR: same address fields as AW; hold until ar_ready.
// - R: r_ready=1. Per beat compare data against expected beat k; any differing
//   lane counts 1 (saturate at 16'hFFFF).
//   rresp!=OKAY, rid!=TxnId, or rlast!=(k==num-1) sets resp_err.
//   Exit R on the beat where k==num-1, regardless of rlast.
// - DONE: done_o=1 for exactly one cycle, busy_o drops that cycle; status holds.
// - Latency with zero-wait slave: AW 1 cycle, W num cycles, B/AR/R as slave
//   permits; no idle bubbles inserted by this block.
// - Async reset mid-burst aborts immediately; valids drop without completing
//   the handshake. Acceptable for VIP; the bench resets the slave together.
// STRUCTURE
// - State enum and the pattern function pat(seed,k,DataWidth) go in package
//   vip_carfield_pkg, shared with the bench scoreboard.
// - Single module, no sub-module. One beat counter shared by W and R; 4 KiB
//   check done combinationally on the latched config.
// TESTING
// 1 base=0x8000_0000, num=4, seed=0x1000_0000, axi_sim_mem slave, zero wait ->
//   W beats 0x10000000_10000000..0x10000003_10000003; done; mismatch=0; no errors.
// 2 Same config with random ready backpressure (0-5 cycles) on all channels ->
//   identical result; valid/payload never change before ready (assertion).
// 3 Slave flips bit 0 of read beat 2 -> mismatch=1, resp_err=0.
// 4 base=0xFF8, num=4 (crosses 0x1000) -> cfg_err=1, done pulse, aw/ar_valid never high.
// 5 Slave returns BRESP=SLVERR -> resp_err=1, ar_valid never asserted, done pulses.
// 6 Reset asserted during W beat 1 -> all outputs 0 next edge; new start -> clean pass.

Source files
------------

// File: rtl/vip_carfield_pkg.sv
// Shared types for the carfield external-port AXI traffic generator: FSM states,
// AXI channel structs and the deterministic beat pattern.
package vip_carfield_pkg;

  localparam int unsigned AXI_ADDR_W = 48;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_ID_W   = 2;
  localparam int unsigned AXI_USER_W = 1;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DONE
  } tg_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [AXI_USER_W-1:0] user;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
    logic [AXI_USER_W-1:0]   user;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } carfield_axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } carfield_axi_rsp_t;

  // Beat k carries seed+k in every 32-bit lane of a dw-bit bus.
  function automatic logic [AXI_DATA_W-1:0] pat(input logic [31:0] seed,
                                                input logic [31:0] k,
                                                input int unsigned dw);
    logic [AXI_DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < int'(AXI_DATA_W / 32); i++)
      if (i < int'(dw / 32)) d[i*32 +: 32] = seed + k;
    return d;
  endfunction

endpackage

// File: rtl/vip_axi_ext_traffic_gen.sv
// Self-checking AXI4 master: one INCR write burst of a seeded pattern, read back
// of the same range, compare, and report status on one external VIP port.
module vip_axi_ext_traffic_gen
  import vip_carfield_pkg::*;
#(
  parameter int unsigned AddrWidth = AXI_ADDR_W,
  parameter int unsigned DataWidth = AXI_DATA_W,
  parameter int unsigned IdWidth   = AXI_ID_W,
  parameter int unsigned UserWidth = AXI_USER_W,
  parameter int unsigned TxnId     = 0,
  parameter int unsigned MaxBeats  = 256,
  parameter type axi_req_t = vip_carfield_pkg::carfield_axi_req_t,
  parameter type axi_rsp_t = vip_carfield_pkg::carfield_axi_rsp_t
)(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [AddrWidth-1:0]        base_addr_i,
  input  logic [$clog2(MaxBeats):0]   num_beats_i,
  input  logic [31:0]                 seed_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        cfg_err_o,
  output logic                        resp_err_o,
  output logic [15:0]                 mismatch_o,
  output axi_req_t                    axi_req_o,
  input  axi_rsp_t                    axi_rsp_i
);

  localparam int unsigned NumW    = $clog2(MaxBeats) + 1;
  localparam int unsigned StrbW   = DataWidth / 8;
  localparam int unsigned SizeLog = $clog2(StrbW);
  localparam int unsigned EndW    = NumW + SizeLog + 13;
  localparam logic [IdWidth-1:0]   AxId     = IdWidth'(TxnId);
  localparam logic [UserWidth-1:0] UserZero = '0;

  tg_state_e            state_q, state_d;
  logic [AddrWidth-1:0] base_q, base_n;
  logic [NumW-1:0]      num_q, num_n;
  logic [31:0]          seed_q, seed_n;
  logic [NumW-1:0]      beat_q, beat_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 resp_err_q, resp_err_d;
  logic [15:0]          mism_q, mism_d;

  logic                 accept, cfg_bad, last_beat;
  logic [EndW-1:0]      burst_end;
  logic [DataWidth-1:0] exp_data;
  axi_ax_t              ax;

  assign accept = (state_q == ST_IDLE) && start_i;
  assign base_n = accept ? base_addr_i : base_q;
  assign num_n  = accept ? num_beats_i : num_q;
  assign seed_n = accept ? seed_i      : seed_q;

  // Byte offset just past the burst within its 4 KiB page; > 4096 means it crosses.
  assign burst_end = EndW'(base_n[11:0]) + (EndW'(num_n) << SizeLog);
  assign cfg_bad   = (num_n == '0) || (num_n > NumW'(MaxBeats)) ||
                     (burst_end > EndW'(4096));

  assign last_beat = (beat_q == num_q - 1'b1);
  assign exp_data  = DataWidth'(pat(seed_q, 32'(beat_q), DataWidth));

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cfg_err_d  = cfg_err_q;
    resp_err_d = resp_err_q;
    mism_d     = mism_q;
    unique case (state_q)
      ST_IDLE: if (start_i) begin
        cfg_err_d  = cfg_bad;
        resp_err_d = 1'b0;
        mism_d     = '0;
        beat_d     = '0;
        state_d    = cfg_bad ? ST_DONE : ST_AW;
      end
      ST_AW: if (axi_rsp_i.aw_ready) state_d = ST_W;
      ST_W: if (axi_rsp_i.w_ready) begin
        beat_d = beat_q + 1'b1;
        if (last_beat) begin
          beat_d  = '0;
          state_d = ST_B;
        end
      end
      ST_B: if (axi_rsp_i.b_valid) begin
        if (axi_rsp_i.b.resp != RESP_OKAY || axi_rsp_i.b.id != AxId) begin
          resp_err_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_AR: if (axi_rsp_i.ar_ready) state_d = ST_R;
      ST_R: if (axi_rsp_i.r_valid) begin
        if (axi_rsp_i.r.data != exp_data && mism_q != 16'hFFFF)
          mism_d = mism_q + 16'd1;
        if (axi_rsp_i.r.resp != RESP_OKAY || axi_rsp_i.r.id != AxId ||
            axi_rsp_i.r.last != last_beat)
          resp_err_d = 1'b1;
        beat_d = beat_q + 1'b1;
        // Leave on the beat count alone so a missing RLAST cannot hang the port.
        if (last_beat) begin
          beat_d  = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      seed_q     <= '0;
      beat_q     <= '0;
      cfg_err_q  <= 1'b0;
      resp_err_q <= 1'b0;
      mism_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_n;
      num_q      <= num_n;
      seed_q     <= seed_n;
      beat_q     <= beat_d;
      cfg_err_q  <= cfg_err_d;
      resp_err_q <= resp_err_d;
      mism_q     <= mism_d;
    end
  end

  // AW and AR share one address descriptor built from the latched config.
  always_comb begin
    ax        = '0;
    ax.id     = AxId;
    ax.addr   = base_q;
    ax.len    = 8'(num_q - 1'b1);
    ax.size   = 3'(SizeLog);
    ax.burst  = BURST_INCR;
    ax.user   = UserZero;

    axi_req_o          = '0;
    axi_req_o.aw       = ax;
    axi_req_o.aw_valid = (state_q == ST_AW);
    axi_req_o.w.data   = exp_data;
    axi_req_o.w.strb   = '1;
    axi_req_o.w.last   = last_beat;
    axi_req_o.w.user   = UserZero;
    axi_req_o.w_valid  = (state_q == ST_W);
    axi_req_o.b_ready  = (state_q == ST_B);
    axi_req_o.ar       = ax;
    axi_req_o.ar_valid = (state_q == ST_AR);
    axi_req_o.r_ready  = (state_q == ST_R);
  end

  assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o     = (state_q == ST_DONE);
  assign cfg_err_o  = cfg_err_q;
  assign resp_err_o = resp_err_q;
  assign mismatch_o = mism_q;

  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.b.user, axi_rsp_i.r.user};

endmodule

// File: tb/tb_vip_axi_ext_traffic_gen.sv
// Bench for vip_axi_ext_traffic_gen: memory-backed AXI slave with optional
// backpressure and fault injection, directed plus randomized burst scenarios.
module tb_vip_axi_ext_traffic_gen;
  import vip_carfield_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [47:0] base = '0;
  logic [8:0]  num = '0;
  logic [31:0] seed = '0;
  logic        busy, done, cfg_err, resp_err;
  logic [15:0] mismatch;
  carfield_axi_req_t req;
  carfield_axi_rsp_t rsp = '0;

  always #5 clk = ~clk;

  vip_axi_ext_traffic_gen #(
    .AddrWidth(48), .DataWidth(64), .IdWidth(2), .UserWidth(1), .TxnId(0),
    .MaxBeats(256), .axi_req_t(carfield_axi_req_t), .axi_rsp_t(carfield_axi_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base),
    .num_beats_i(num), .seed_i(seed), .busy_o(busy), .done_o(done),
    .cfg_err_o(cfg_err), .resp_err_o(resp_err), .mismatch_o(mismatch),
    .axi_req_o(req), .axi_rsp_i(rsp)
  );

  int total = 0, passed = 0, failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [63:0] mem [logic [47:0]];
  int  bp_max = 0;
  bit  flip_r2 = 0, b_slverr = 0;
  int  aw_hs, ar_hs, w_hs, aw_vcyc, ar_vcyc, w_vcyc, wlast_err, strb_err;
  logic [47:0] cap_aw_addr, cap_ar_addr;
  logic [7:0]  cap_aw_len, cap_ar_len;
  logic [2:0]  cap_aw_size;
  logic [1:0]  cap_aw_burst, aw_id, ar_id;
  int  aw_wait, w_wait, b_wait, ar_wait, r_wait, w_idx, r_idx;
  bit  b_pend, r_act;
  carfield_axi_req_t req_prev = '0;
  carfield_axi_rsp_t rsp_prev = '0;

  function automatic int rnd();
    return (bp_max == 0) ? 0 : int'($urandom_range(bp_max, 0));
  endfunction

  // Driven at negedge: DUT valids/readies depend only on its state, so a
  // handshake at the coming posedge is known here and booked immediately.
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp = '0; req_prev = '0; rsp_prev = '0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      w_idx = 0; r_idx = 0; b_pend = 0; r_act = 0;
    end else begin
      if (req_prev.aw_valid && !rsp_prev.aw_ready)
        chk("aw_hold", req.aw_valid && (req.aw == req_prev.aw), 1);
      if (req_prev.w_valid && !rsp_prev.w_ready)
        chk("w_hold", req.w_valid && (req.w == req_prev.w), 1);
      if (req_prev.ar_valid && !rsp_prev.ar_ready)
        chk("ar_hold", req.ar_valid && (req.ar == req_prev.ar), 1);

      rsp.b_valid = 1'b0;
      if (b_pend) begin
        if (b_wait > 0) b_wait--;
        else begin
          rsp.b_valid = 1'b1; rsp.b.id = aw_id; rsp.b.user = '0;
          rsp.b.resp = b_slverr ? 2'b10 : 2'b00;
          if (req.b_ready) b_pend = 0;
        end
      end

      rsp.r_valid = 1'b0;
      if (r_act) begin
        if (r_wait > 0) r_wait--;
        else begin
          logic [47:0] a;
          a = cap_ar_addr + 48'(r_idx * 8);
          rsp.r_valid = 1'b1; rsp.r.id = ar_id; rsp.r.resp = 2'b00; rsp.r.user = '0;
          rsp.r.data = mem.exists(a) ? mem[a] : 64'h0;
          if (flip_r2 && r_idx == 2) rsp.r.data[0] = ~rsp.r.data[0];
          rsp.r.last = (r_idx == int'(cap_ar_len));
          if (req.r_ready) begin
            r_idx++; r_wait = rnd();
            if (r_idx > int'(cap_ar_len)) r_act = 0;
          end
        end
      end

      rsp.aw_ready = 1'b0;
      if (req.aw_valid) begin
        aw_vcyc++;
        if (aw_wait > 0) aw_wait--;
        else begin
          rsp.aw_ready = 1'b1; aw_hs++; aw_wait = rnd(); w_idx = 0;
          cap_aw_addr = req.aw.addr; cap_aw_len = req.aw.len; aw_id = req.aw.id;
          cap_aw_size = req.aw.size; cap_aw_burst = req.aw.burst;
        end
      end

      rsp.w_ready = 1'b0;
      if (req.w_valid) begin
        w_vcyc++;
        if (w_wait > 0) w_wait--;
        else begin
          rsp.w_ready = 1'b1; w_hs++; w_wait = rnd();
          mem[cap_aw_addr + 48'(w_idx * 8)] = req.w.data;
          if (req.w.strb != 8'hFF) strb_err++;
          if (req.w.last != (w_idx == int'(cap_aw_len))) wlast_err++;
          w_idx++;
          if (w_idx > int'(cap_aw_len)) begin b_pend = 1; b_wait = rnd(); end
        end
      end

      rsp.ar_ready = 1'b0;
      if (req.ar_valid) begin
        ar_vcyc++;
        if (ar_wait > 0) ar_wait--;
        else begin
          rsp.ar_ready = 1'b1; ar_hs++; ar_wait = rnd();
          cap_ar_addr = req.ar.addr; cap_ar_len = req.ar.len; ar_id = req.ar.id;
          r_act = 1; r_idx = 0; r_wait = rnd();
        end
      end
      req_prev = req; rsp_prev = rsp;
    end
  end

  // ---------------- directed sequence ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clr_stats();
    aw_hs = 0; ar_hs = 0; w_hs = 0; aw_vcyc = 0; ar_vcyc = 0; w_vcyc = 0;
    wlast_err = 0; strb_err = 0;
  endtask

  task automatic run_test(input string tag, input logic [47:0] b, input logic [8:0] n,
                          input logic [31:0] s, input bit zero_wait);
    int cyc, bad;
    bit exp_cfg, exp_rd;
    int exp_mism;
    exp_cfg  = (n == 0) || (n > 256) || (int'(b % 4096) + int'(n) * 8 > 4096);
    exp_rd   = !exp_cfg && !b_slverr;
    exp_mism = (exp_rd && flip_r2 && n > 2) ? 1 : 0;
    step(); clr_stats();
    base = b; num = n; seed = s; start = 1'b1;
    step(); start = 1'b0;
    if (!exp_cfg) chk({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 5000) begin step(); cyc++; end
    chk({tag, "_done"}, done, 1);
    if (exp_cfg) chk({tag, "_cfg_lat"}, cyc, 0);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_status"}, {cfg_err, resp_err, mismatch},
        {exp_cfg, b_slverr && !exp_cfg, 16'(exp_mism)});
    step();
    chk({tag, "_done_pulse"}, {done, busy}, 0);
    chk({tag, "_status_hold"}, {cfg_err, resp_err, mismatch},
        {exp_cfg, b_slverr && !exp_cfg, 16'(exp_mism)});
    chk({tag, "_aw_ar_cnt"}, {aw_hs[7:0], ar_hs[7:0]}, {exp_cfg ? 8'd0 : 8'd1, exp_rd ? 8'd1 : 8'd0});
    if (exp_cfg) chk({tag, "_no_axvalid"}, aw_vcyc + ar_vcyc + w_vcyc, 0);
    if (!exp_rd) chk({tag, "_no_arvalid"}, ar_vcyc, 0);
    if (!exp_cfg) begin
      chk({tag, "_aw_fields"}, {cap_aw_addr, cap_aw_len, cap_aw_size, cap_aw_burst},
          {b, 8'(n - 1), 3'd3, 2'b01});
      chk({tag, "_w_fmt"}, {w_hs[15:0], 16'(wlast_err), 16'(strb_err)}, {16'(n), 32'd0});
      bad = 0;
      for (int k = 0; k < int'(n); k++) begin
        logic [31:0] v;
        v = s + 32'(k);
        if (!mem.exists(b + 48'(k * 8)) || mem[b + 48'(k * 8)] !== {v, v}) bad++;
      end
      chk({tag, "_wdata"}, bad, 0);
      if (zero_wait) chk({tag, "_aw_w_cycles"}, {aw_vcyc[15:0], w_vcyc[15:0]}, {16'd1, 16'(n)});
    end
    if (exp_rd) chk({tag, "_ar_fields"}, {cap_ar_addr, cap_ar_len}, {b, 8'(n - 1)});
  endtask

  initial begin
    int cyc;
    repeat (3) step();
    chk("reset_outputs", {busy, done, cfg_err, resp_err, mismatch, req.aw_valid,
        req.w_valid, req.ar_valid, req.b_ready, req.r_ready}, 0);
    rst_n = 1'b1;
    step();

    run_test("t1_zero_wait", 48'h8000_0000, 9'd4, 32'h1000_0000, 1);
    bp_max = 5;
    run_test("t2_backpressure", 48'h8000_0000, 9'd4, 32'h1000_0000, 0);
    for (int i = 0; i < 4; i++)
      run_test("t2_random", 48'h8000_0000 + 48'($urandom_range(511, 0) * 8),
               9'($urandom_range(32, 1)), $urandom, 0);
    bp_max = 0;
    flip_r2 = 1;
    run_test("t3_flip_beat2", 48'h8000_2000, 9'd4, 32'hCAFE_0000, 0);
    flip_r2 = 0;
    run_test("t4_cross_4k", 48'h0000_0FF8, 9'd4, 32'h1, 0);
    run_test("t4_zero_beats", 48'h0000_0000, 9'd0, 32'h1, 0);
    run_test("t4_too_many", 48'h0000_0000, 9'd257, 32'h1, 0);
    run_test("t4_end_at_4k", 48'h0000_0F00, 9'd32, 32'hFFFF_FFF0, 1);
    run_test("t4_max_beats", 48'h0001_0000, 9'd256, 32'h5555_0000, 1);
    b_slverr = 1;
    run_test("t5_bresp_slverr", 48'h8000_3000, 9'd4, 32'h2, 0);
    b_slverr = 0;

    // Reset while beat 1 of the write burst is on the bus.
    step(); clr_stats();
    base = 48'h8000_4000; num = 9'd4; seed = 32'h7; start = 1'b1;
    step(); start = 1'b0;
    cyc = 0;
    while (w_hs < 1 && cyc < 100) begin step(); cyc++; end
    chk("t6_reached_w1", {w_hs[7:0], req.w_valid}, {8'd1, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("t6_async_clear", {busy, done, req.aw_valid, req.w_valid, req.ar_valid}, 0);
    step();
    chk("t6_outputs_zero", {busy, done, cfg_err, resp_err, mismatch, req.aw_valid,
        req.w_valid, req.ar_valid, req.b_ready, req.r_ready}, 0);
    step();
    rst_n = 1'b1;
    step();
    run_test("t6_after_reset", 48'h8000_4000, 9'd4, 32'h7, 1);

    repeat (2) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
